// File: rtl/elevator_car_ctrl_if.sv
// Scheduler-facing bundle for one elevator car.
// The scheduler drives the dispatch and safety inputs; the car controller reports position and status.
interface elevator_car_ctrl_if;
    logic       moveEnable;
    logic [1:0] target;
    logic       estop;
    logic       doorObstruct;
    logic [1:0] currentFloor;
    logic       busy;
    logic       movingUp;
    logic       movingDown;
    logic       doorOpen;
    logic       arrived;

    modport master (
        output moveEnable, target, estop, doorObstruct,
        input  currentFloor, busy, movingUp, movingDown, doorOpen, arrived
    );

    modport slave (
        input  moveEnable, target, estop, doorObstruct,
        output currentFloor, busy, movingUp, movingDown, doorOpen, arrived
    );
endinterface

// File: rtl/elevator_car_ctrl.sv
// Single-car controller for a four-floor shaft: accepts one dispatch while idle,
// travels floor by floor on a tick counter, then holds the door open before going idle.
module elevator_car_ctrl #(
    parameter int FLOOR_TICKS = 4,
    parameter int DOOR_TICKS  = 3
) (
    input  logic               clk,
    input  logic               rst,
    elevator_car_ctrl_if.slave io_car
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2,
        DOOR_OPEN = 2'd3
    } state_t;

    localparam logic [7:0] FLOOR_LAST = 8'(FLOOR_TICKS - 1);
    localparam logic [7:0] DOOR_LAST  = 8'(DOOR_TICKS - 1);
    localparam logic [1:0] TOP_FLOOR  = 2'd3;
    localparam logic [1:0] GND_FLOOR  = 2'd0;

    state_t     r_state;
    state_t     w_nextState;
    logic [1:0] r_floor;
    logic [1:0] w_nextFloor;
    logic [1:0] r_tgt;
    logic [1:0] w_nextTgt;
    logic [7:0] r_travelCnt;
    logic [7:0] w_nextTravelCnt;
    logic [7:0] r_doorCnt;
    logic [7:0] w_nextDoorCnt;
    logic [1:0] w_stepFloor;
    logic       r_busy;
    logic       r_movingUp;
    logic       r_movingDown;
    logic       r_doorOpen;
    logic       r_arrived;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // An asserted estop holds every default, which freezes state, floor and both counters.
    always_comb begin
        w_nextState     = r_state;
        w_nextFloor     = r_floor;
        w_nextTgt       = r_tgt;
        w_nextTravelCnt = r_travelCnt;
        w_nextDoorCnt   = r_doorCnt;
        w_stepFloor     = r_floor;
        if (!io_car.estop) begin
            case (r_state)
                IDLE: begin
                    if (io_car.moveEnable) begin
                        w_nextTgt       = io_car.target;
                        w_nextTravelCnt = 8'd0;
                        w_nextDoorCnt   = 8'd0;
                        if (io_car.target > r_floor) begin
                            w_nextState = MOVE_UP;
                        end else if (io_car.target < r_floor) begin
                            w_nextState = MOVE_DOWN;
                        end else begin
                            w_nextState = DOOR_OPEN;
                        end
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (r_travelCnt == FLOOR_LAST) begin
                        // Saturate at the shaft ends so the floor can never wrap.
                        if (r_state == MOVE_UP) begin
                            w_stepFloor = (r_floor == TOP_FLOOR) ? r_floor : r_floor + 2'd1;
                        end else begin
                            w_stepFloor = (r_floor == GND_FLOOR) ? r_floor : r_floor - 2'd1;
                        end
                        w_nextFloor     = w_stepFloor;
                        w_nextTravelCnt = 8'd0;
                        if (w_stepFloor == r_tgt) begin
                            w_nextState   = DOOR_OPEN;
                            w_nextDoorCnt = 8'd0;
                        end
                    end else begin
                        w_nextTravelCnt = r_travelCnt + 8'd1;
                    end
                end
                DOOR_OPEN: begin
                    if (io_car.doorObstruct) begin
                        w_nextDoorCnt = 8'd0;
                    end else if (r_doorCnt == DOOR_LAST) begin
                        w_nextState   = IDLE;
                        w_nextDoorCnt = 8'd0;
                    end else begin
                        w_nextDoorCnt = r_doorCnt + 8'd1;
                    end
                end
                default: begin
                    w_nextState = IDLE;
                end
            endcase
        end
    end

    // Status flags are registered from the next state so they line up with r_state exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_floor      <= 2'd0;
            r_tgt        <= 2'd0;
            r_travelCnt  <= 8'd0;
            r_doorCnt    <= 8'd0;
            r_busy       <= 1'b0;
            r_movingUp   <= 1'b0;
            r_movingDown <= 1'b0;
            r_doorOpen   <= 1'b0;
            r_arrived    <= 1'b0;
        end else begin
            r_floor      <= w_nextFloor;
            r_tgt        <= w_nextTgt;
            r_travelCnt  <= w_nextTravelCnt;
            r_doorCnt    <= w_nextDoorCnt;
            r_busy       <= (w_nextState != IDLE);
            r_movingUp   <= (w_nextState == MOVE_UP);
            r_movingDown <= (w_nextState == MOVE_DOWN);
            r_doorOpen   <= (w_nextState == DOOR_OPEN);
            r_arrived    <= (w_nextState == DOOR_OPEN) && (r_state != DOOR_OPEN);
        end
    end

    // Motion indicators drop in the same cycle estop is raised, not one cycle later.
    assign io_car.currentFloor = r_floor;
    assign io_car.busy         = r_busy;
    assign io_car.movingUp     = r_movingUp & ~io_car.estop;
    assign io_car.movingDown   = r_movingDown & ~io_car.estop;
    assign io_car.doorOpen     = r_doorOpen;
    assign io_car.arrived      = r_arrived;
endmodule

// File: doc/elevator_car_ctrl.md
ELEVATOR_CAR_CTRL -- requirements
Module: elevator_car_ctrl

Interface
REQ-001 The block SHALL have parameter FLOOR_TICKS, default 4, clock cycles to travel one floor (legal 2..255).
REQ-002 The block SHALL have parameter DOOR_TICKS, default 3, clock cycles the door stays open (legal 2..255).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 move_enable  input  1  one-cycle dispatch strobe from scheduler.
REQ-006 target  input  2  dispatched floor (0=G..3); sampled only with accepted move_enable.
REQ-007 estop  input  1  emergency stop, level.
REQ-008 door_obstruct  input  1  door sensor, level.
REQ-009 current_floor  output  2  registered car position.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 moving_up / moving_down  output  1 each  high in MOVE_UP / MOVE_DOWN while estop=0; never both high.
REQ-012 door_open  output  1  high in DOOR_OPEN.
REQ-013 arrived  output  1  one-cycle pulse on entry to DOOR_OPEN.

Function
REQ-014 FSM states SHALL be IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN; all outputs SHALL be driven from registers.
REQ-015 IDLE: move_enable=1 and estop=0 at an edge SHALL latch target into tgt_q and go to MOVE_UP if target>current_floor, MOVE_DOWN if target<current_floor, DOOR_OPEN if equal; busy high from the next cycle.
REQ-016 move_enable SHALL be ignored in any state other than IDLE and in IDLE while estop=1; tgt_q unchanged.
REQ-017 MOVE_*: 8-bit travel counter SHALL increment each cycle from 0; at the edge where it equals FLOOR_TICKS-1, current_floor SHALL step +1 (UP) or -1 (DOWN) and counter SHALL clear.
REQ-018 If the stepped floor equals tgt_q, the same edge SHALL enter DOOR_OPEN and pulse arrived for the following cycle; otherwise the state SHALL be held.
REQ-019 Arrival latency SHALL be exactly |target-floor|*FLOOR_TICKS cycles after the accept edge with no estop; same-floor dispatch SHALL enter DOOR_OPEN at the accept edge (arrived pulses next cycle).
REQ-020 current_floor SHALL never wrap: no step below 0 or above 3.
REQ-021 DOOR_OPEN: 8-bit door counter SHALL start at 0 on entry and increment each cycle; door_obstruct=1 SHALL reset it to 0; at the edge where it equals DOOR_TICKS-1 with door_obstruct=0, state SHALL go to IDLE.
REQ-022 estop=1 SHALL freeze both counters, state and current_floor, force moving_up/moving_down to 0, and keep busy and door_open at their current values; on release, operation SHALL resume from the frozen counts.
REQ-023 estop and door_obstruct both high in DOOR_OPEN: estop SHALL take priority (counter frozen, not cleared).

Reset
REQ-024 rst=1 SHALL immediately force state IDLE, current_floor=0, tgt_q=0, both counters=0, busy=0, moving_up=0, moving_down=0, door_open=0, arrived=0.
REQ-025 Reset asserted mid-travel or mid-door SHALL abandon the trip; first move_enable after release SHALL be accepted normally.

Verification (FLOOR_TICKS=4, DOOR_TICKS=3, accept edge = cycle 0)
REQ-026 After reset, move_enable with target=3 -> busy/moving_up from cycle 1; current_floor 1,2,3 at edges 4,8,12; arrived pulse cycle 13; door_open cycles 13-15; busy=0 from cycle 16.
REQ-027 At floor 0, target=0 -> no motion, door_open cycles 1-3, arrived cycle 1, IDLE from cycle 4.
REQ-028 At floor 3, target=0 then move_enable target=2 at cycle 5 -> second strobe ignored, moving_down, car reaches 0 at edge 12, tgt_q stays 0.
REQ-029 door_obstruct high for 2 cycles mid-door -> door_open extended, IDLE only after 3 consecutive unobstructed cycles.
REQ-030 estop high cycles 5-9 on trip 0->2 -> moving_up low during those cycles, floor frozen, arrival at edge 13 instead of 8.
REQ-031 rst pulse at cycle 6 of trip 0->3 -> current_floor=0, busy=0 immediately; new dispatch to 1 arrives at edge 4 after accept.
